// File: rtl/ibex_pmp_csr_if.sv
// PMP CSR access bus: write strobe/address/data in, combinational read data and hit out.
// Latency: none (bundle of wires).
// Backpressure: none; every asserted write strobe is one access.

package ibex_pmp_pkg;

  typedef enum logic [1:0] {
    PMP_MODE_OFF   = 2'b00,
    PMP_MODE_TOR   = 2'b01,
    PMP_MODE_NA4   = 2'b10,
    PMP_MODE_NAPOT = 2'b11
  } pmp_cfg_mode_e;

  typedef struct packed {
    logic          lock;
    pmp_cfg_mode_e mode;
    logic          exec;
    logic          write;
    logic          read;
  } pmp_cfg_t;

  typedef struct packed {
    logic rlb;
    logic mmwp;
    logic mml;
  } pmp_mseccfg_t;

endpackage

interface ibex_pmp_csr_if;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_hit_o;

  modport master (
    output csr_we_i, csr_addr_i, csr_wdata_i,
    input  csr_rdata_o, csr_hit_o
  );

  modport slave (
    input  csr_we_i, csr_addr_i, csr_wdata_i,
    output csr_rdata_o, csr_hit_o
  );
endinterface

// File: rtl/ibex_pmp_csr.sv
// PMP CSR file: pmpcfg0-3, pmpaddr0-15, mseccfg/mseccfgh; optional rule-locking bypass via IBEX_PMP_RLB_EN.
// Latency: reads combinational; writes visible one cycle later, pmp_changed_o pulses the cycle after a real change.
// Backpressure: none; writes are accepted or silently dropped by the lock/legality rules.

module ibex_pmp_csr
  import ibex_pmp_pkg::*;
#(
  parameter int PMPNumRegions  = 4,
  parameter int PMPGranularity = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  ibex_pmp_csr_if.slave csr,
  output pmp_cfg_t      csr_pmp_cfg_o  [PMPNumRegions],
  output logic [33:0]   csr_pmp_addr_o [PMPNumRegions],
  output pmp_mseccfg_t  csr_pmp_mseccfg_o,
  output logic          pmp_changed_o
);

  localparam logic [11:0] CfgBase  = 12'h3A0;
  localparam logic [11:0] AddrBase = 12'h3B0;
  localparam logic [11:0] SecCfg   = 12'h747;
  localparam logic [11:0] SecCfgH  = 12'h757;

  function automatic logic [31:0] low_ones(int n);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 32; b++) if (b < n) m[b] = 1'b1;
    return m;
  endfunction

  // Address bits below the granule: forced to 1 in NAPOT reads, 0 in OFF/TOR reads.
  localparam logic [31:0] NapotOnes = low_ones(PMPGranularity - 1);
  localparam logic [31:0] GranMask  = low_ones(PMPGranularity);

  function automatic pmp_cfg_t legalize(logic [7:0] b, logic mml);
    pmp_cfg_t c;
    c.lock  = b[7];
    c.mode  = pmp_cfg_mode_e'(b[4:3]);
    c.exec  = b[2];
    c.read  = b[0];
    c.write = mml ? b[1] : (b[1] & b[0]);
    if (PMPGranularity >= 1 && c.mode == PMP_MODE_NA4) c.mode = PMP_MODE_OFF;
    return c;
  endfunction

  function automatic logic [7:0] cfg_byte(pmp_cfg_t c);
    return {c.lock, 2'b00, c.mode, c.exec, c.write, c.read};
  endfunction

  pmp_cfg_t    cfg_q  [PMPNumRegions];
  pmp_cfg_t    cfg_d  [PMPNumRegions];
  pmp_cfg_t    wcfg   [PMPNumRegions];
  logic [31:0] addr_q [PMPNumRegions];
  logic [31:0] addr_d [PMPNumRegions];
  logic        mml_q, mml_d, mmwp_q, mmwp_d;
  logic        rlb;
  logic        changed_d, changed_q;
  logic [PMPNumRegions-1:0] locked, addr_locked, mml_reject;

`ifdef IBEX_PMP_RLB_EN
  logic rlb_q, rlb_d;
  logic any_lock;
  assign rlb = rlb_q;

  // Setting rlb is refused once any region has been locked.
  always_comb begin
    any_lock = 1'b0;
    for (int r = 0; r < PMPNumRegions; r++) any_lock = any_lock | cfg_q[r].lock;
  end
`else
  assign rlb = 1'b0;
`endif

  // Per-region lock state and legalized candidate cfg from the write data.
  always_comb begin
    for (int r = 0; r < PMPNumRegions; r++) begin
      locked[r]      = cfg_q[r].lock & ~rlb;
      addr_locked[r] = locked[r];
      wcfg[r]        = legalize(csr.csr_wdata_i[8*(r%4) +: 8], mml_q);
      mml_reject[r]  = mml_q & ~rlb & wcfg[r].lock &
                       ((wcfg[r].exec & ~(wcfg[r].read & wcfg[r].write)) |
                        (~wcfg[r].read & wcfg[r].write));
    end
    for (int r = 0; r < PMPNumRegions - 1; r++) begin
      addr_locked[r] = addr_locked[r] |
                       (locked[r+1] & (cfg_q[r+1].mode == PMP_MODE_TOR));
    end
  end

  // Next state: apply the single write of this cycle, checked against pre-write state.
  always_comb begin
    cfg_d  = cfg_q;
    addr_d = addr_q;
    mml_d  = mml_q;
    mmwp_d = mmwp_q;
`ifdef IBEX_PMP_RLB_EN
    rlb_d  = rlb_q;
`endif
    if (csr.csr_we_i) begin
      for (int r = 0; r < PMPNumRegions; r++) begin
        if (csr.csr_addr_i == CfgBase + 12'(r / 4) && !locked[r] && !mml_reject[r]) begin
          cfg_d[r] = wcfg[r];
        end
        if (csr.csr_addr_i == AddrBase + 12'(r) && !addr_locked[r]) begin
          addr_d[r] = csr.csr_wdata_i;
        end
      end
      if (csr.csr_addr_i == SecCfg) begin
        mml_d  = mml_q  | csr.csr_wdata_i[0];
        mmwp_d = mmwp_q | csr.csr_wdata_i[1];
`ifdef IBEX_PMP_RLB_EN
        if (!(csr.csr_wdata_i[2] && !rlb_q && any_lock)) rlb_d = csr.csr_wdata_i[2];
`endif
      end
    end
  end

  // Detect whether any stored bit will actually flip.
  always_comb begin
    changed_d = (mml_d != mml_q) || (mmwp_d != mmwp_q);
`ifdef IBEX_PMP_RLB_EN
    changed_d = changed_d || (rlb_d != rlb_q);
`endif
    for (int r = 0; r < PMPNumRegions; r++) begin
      changed_d = changed_d || (cfg_d[r] != cfg_q[r]) || (addr_d[r] != addr_q[r]);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < PMPNumRegions; r++) begin
        cfg_q[r]  <= '0;
        addr_q[r] <= '0;
      end
      mml_q     <= 1'b0;
      mmwp_q    <= 1'b0;
      changed_q <= 1'b0;
`ifdef IBEX_PMP_RLB_EN
      rlb_q     <= 1'b0;
`endif
    end else begin
      for (int r = 0; r < PMPNumRegions; r++) begin
        cfg_q[r]  <= cfg_d[r];
        addr_q[r] <= addr_d[r];
      end
      mml_q     <= mml_d;
      mmwp_q    <= mmwp_d;
      changed_q <= changed_d;
`ifdef IBEX_PMP_RLB_EN
      rlb_q     <= rlb_d;
`endif
    end
  end

  // Combinational read mux; unimplemented regions and mseccfgh read as zero.
  always_comb begin
    csr.csr_rdata_o = '0;
    for (int r = 0; r < PMPNumRegions; r++) begin
      if (csr.csr_addr_i == CfgBase + 12'(r / 4)) begin
        csr.csr_rdata_o[8*(r%4) +: 8] = cfg_byte(cfg_q[r]);
      end
      if (csr.csr_addr_i == AddrBase + 12'(r)) begin
        csr.csr_rdata_o = (cfg_q[r].mode == PMP_MODE_NAPOT) ? (addr_q[r] | NapotOnes)
                                                             : (addr_q[r] & ~GranMask);
      end
    end
    if (csr.csr_addr_i == SecCfg) csr.csr_rdata_o = {29'b0, rlb, mmwp_q, mml_q};
  end

  assign csr.csr_hit_o = (csr.csr_addr_i >= CfgBase  && csr.csr_addr_i <= CfgBase + 12'h3) ||
                         (csr.csr_addr_i >= AddrBase && csr.csr_addr_i <= AddrBase + 12'hF) ||
                         (csr.csr_addr_i == SecCfg)  || (csr.csr_addr_i == SecCfgH);

  // Drive stored state to the PMP checker.
  always_comb begin
    for (int r = 0; r < PMPNumRegions; r++) begin
      csr_pmp_cfg_o[r]  = cfg_q[r];
      csr_pmp_addr_o[r] = {addr_q[r], 2'b00};
    end
  end

  assign csr_pmp_mseccfg_o = '{rlb: rlb, mmwp: mmwp_q, mml: mml_q};
  assign pmp_changed_o     = changed_q;

endmodule

// File: tb/tb_ibex_pmp_csr.sv
// Bench for ibex_pmp_csr: two instances (4 regions/G=0 and 5 regions/G=2) on identical stimulus.
// Directed vector table plus hand sequences, then random writes checked against a behavioural model.
// Honors IBEX_PMP_RLB_EN the same way the design does.

module tb_ibex_pmp_csr;
  import ibex_pmp_pkg::*;

  localparam int N0 = 4, G0 = 0, N1 = 5, G1 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ibex_pmp_csr_if bus0 ();
  ibex_pmp_csr_if bus1 ();

  pmp_cfg_t     cfg0 [N0];
  logic [33:0]  pa0  [N0];
  pmp_mseccfg_t ms0;
  logic         chg0;
  pmp_cfg_t     cfg1 [N1];
  logic [33:0]  pa1  [N1];
  pmp_mseccfg_t ms1;
  logic         chg1;

  ibex_pmp_csr #(.PMPNumRegions(N0), .PMPGranularity(G0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .csr(bus0.slave),
    .csr_pmp_cfg_o(cfg0), .csr_pmp_addr_o(pa0), .csr_pmp_mseccfg_o(ms0), .pmp_changed_o(chg0)
  );

  ibex_pmp_csr #(.PMPNumRegions(N1), .PMPGranularity(G1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .csr(bus1.slave),
    .csr_pmp_cfg_o(cfg1), .csr_pmp_addr_o(pa1), .csr_pmp_mseccfg_o(ms1), .pmp_changed_o(chg1)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_cfg  [2][16];
  logic [31:0] m_addr [2][16];
  bit          m_mml [2], m_mmwp [2], m_rlb [2];
`ifdef IBEX_PMP_RLB_EN
  localparam bit RlbEn = 1'b1;
`else
  localparam bit RlbEn = 1'b0;
`endif

  function automatic int nr(int d); return d == 1 ? N1 : N0; endfunction
  function automatic int gr(int d); return d == 1 ? G1 : G0; endfunction

  function automatic bit m_locked(int d, int r);
    return m_cfg[d][r][7] && !m_rlb[d];
  endfunction

  function automatic bit m_hit(logic [11:0] a);
    return (a >= 12'h3A0 && a <= 12'h3A3) || (a >= 12'h3B0 && a <= 12'h3BF) ||
           a == 12'h747 || a == 12'h757;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 16; r++) begin
        m_cfg[d][r]  = 8'h00;
        m_addr[d][r] = 32'h0;
      end
      m_mml[d] = 0; m_mmwp[d] = 0; m_rlb[d] = 0;
    end
  endtask

  function automatic logic [31:0] m_read(int d, logic [11:0] a);
    logic [31:0] v;
    int r;
    v = 32'h0;
    if (a >= 12'h3A0 && a <= 12'h3A3) begin
      for (int i = 0; i < 4; i++) begin
        r = int'(a - 12'h3A0) * 4 + i;
        if (r < nr(d)) v[8*i +: 8] = m_cfg[d][r];
      end
    end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
      r = int'(a - 12'h3B0);
      if (r < nr(d)) begin
        v = m_addr[d][r];
        if (gr(d) >= 1) begin
          if (m_cfg[d][r][4:3] == 2'b11) v = v | ((32'd1 << (gr(d) - 1)) - 32'd1);
          else                           v = v & ~((32'd1 << gr(d)) - 32'd1);
        end
      end
    end else if (a == 12'h747) begin
      v = {29'b0, m_rlb[d], m_mmwp[d], m_mml[d]};
    end
    return v;
  endfunction

  task automatic m_write(input int d, input logic [11:0] a, input logic [31:0] w, output bit chg);
    logic [7:0]  oc [16];
    logic [31:0] oa [16];
    bit om, ow, orl, rej, any_l;
    logic [7:0] b;
    int r;
    for (int k = 0; k < 16; k++) begin oc[k] = m_cfg[d][k]; oa[k] = m_addr[d][k]; end
    om = m_mml[d]; ow = m_mmwp[d]; orl = m_rlb[d];
    if (a >= 12'h3A0 && a <= 12'h3A3) begin
      for (int i = 0; i < 4; i++) begin
        r = int'(a - 12'h3A0) * 4 + i;
        if (r < nr(d)) begin
          b = w[8*i +: 8];
          b[6:5] = 2'b00;
          if (!m_mml[d]) b[1] = b[1] & b[0];
          if (gr(d) >= 1 && b[4:3] == 2'b10) b[4:3] = 2'b00;
          rej = m_locked(d, r) ||
                (m_mml[d] && !m_rlb[d] && b[7] &&
                 ((b[2] && b[2:0] != 3'b111) || b[1:0] == 2'b10));
          if (!rej) m_cfg[d][r] = b;
        end
      end
    end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
      r = int'(a - 12'h3B0);
      if (r < nr(d)) begin
        rej = m_locked(d, r) ||
              (r + 1 < nr(d) && m_locked(d, r + 1) && m_cfg[d][r+1][4:3] == 2'b01);
        if (!rej) m_addr[d][r] = w;
      end
    end else if (a == 12'h747) begin
      if (w[0]) m_mml[d] = 1;
      if (w[1]) m_mmwp[d] = 1;
      if (RlbEn) begin
        any_l = 0;
        for (int k = 0; k < nr(d); k++) if (m_cfg[d][k][7]) any_l = 1;
        if (!(w[2] && !m_rlb[d] && any_l)) m_rlb[d] = w[2];
      end
    end
    chg = (om != m_mml[d]) || (ow != m_mmwp[d]) || (orl != m_rlb[d]);
    for (int k = 0; k < 16; k++) if (oc[k] != m_cfg[d][k] || oa[k] != m_addr[d][k]) chg = 1;
  endtask

  // ---------------- DUT access helpers ----------------
  function automatic logic [31:0] get_rd(int d);
    return d == 1 ? bus1.csr_rdata_o : bus0.csr_rdata_o;
  endfunction
  function automatic logic get_hit(int d);
    return d == 1 ? bus1.csr_hit_o : bus0.csr_hit_o;
  endfunction
  function automatic logic get_chg(int d);
    return d == 1 ? chg1 : chg0;
  endfunction

  task automatic drive(input logic we, input logic [11:0] a, input logic [31:0] w);
    bus0.csr_we_i = we; bus0.csr_addr_i = a; bus0.csr_wdata_i = w;
    bus1.csr_we_i = we; bus1.csr_addr_i = a; bus1.csr_wdata_i = w;
  endtask

  // One write: same-cycle read shows old value, then pulse and read-back the cycle after.
  task automatic wr(input logic [11:0] a, input logic [31:0] w);
    bit c [2];
    @(negedge clk);
    drive(1'b1, a, w);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("same_cycle_rdata", get_rd(d), m_read(d, a));
      chk("hit", get_hit(d), m_hit(a));
      m_write(d, a, w, c[d]);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk("pmp_changed", get_chg(d), c[d]);
    drive(1'b0, a, 32'h0);
    #1;
    for (int d = 0; d < 2; d++) chk("readback", get_rd(d), m_read(d, a));
  endtask

  task automatic rd(input logic [11:0] a);
    @(posedge clk);
    #1;
    drive(1'b0, a, 32'h0);
    #1;
    for (int d = 0; d < 2; d++) chk("read", get_rd(d), m_read(d, a));
  endtask

  // Reset with a write held on the bus; the write must be discarded.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 12'h3B3, 32'hDEAD_BEEF);
    m_reset();
    #1;
    chk("reset_changed0", chg0, 1'b0);
    chk("reset_changed1", chg1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(1'b0, 12'h3B3, 32'h0);
    #1;
    chk("reset_discard0", bus0.csr_rdata_o, 32'h0);
    chk("reset_discard1", bus1.csr_rdata_o, 32'h0);
  endtask

  task automatic chk_outputs();
    for (int r = 0; r < N0; r++) begin
      chk("cfg_o0", {cfg0[r].lock, 2'b00, cfg0[r].mode, cfg0[r].exec, cfg0[r].write, cfg0[r].read},
          m_cfg[0][r]);
      chk("addr_o0", pa0[r], {m_addr[0][r], 2'b00});
    end
    for (int r = 0; r < N1; r++) begin
      chk("cfg_o1", {cfg1[r].lock, 2'b00, cfg1[r].mode, cfg1[r].exec, cfg1[r].write, cfg1[r].read},
          m_cfg[1][r]);
      chk("addr_o1", pa1[r], {m_addr[1][r], 2'b00});
    end
    chk("mseccfg_o0", ms0, {m_rlb[0], m_mmwp[0], m_mml[0]});
    chk("mseccfg_o1", ms1, {m_rlb[1], m_mmwp[1], m_mml[1]});
  endtask

  // ---------------- directed vectors (expectations for the 4-region, G=0 instance) ----------------
  typedef struct {
    bit          rst;
    bit          we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_chg;
    bit          exp_hit;
  } vec_t;

  function automatic vec_t mk(bit rs, bit we, logic [11:0] a, logic [31:0] w,
                              logic [31:0] e, bit c, bit h);
    vec_t v;
    v.rst = rs; v.we = we; v.addr = a; v.wdata = w; v.exp_rd = e; v.exp_chg = c; v.exp_hit = h;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [$];
    logic [11:0] a;
    logic [31:0] w;

    drive(1'b0, 12'h000, 32'h0);
    tbl.push_back(mk(0, 0, 12'h3A0, 32'h0,        32'h0000_0000, 0, 1));
    tbl.push_back(mk(0, 0, 12'h3A4, 32'h0,        32'h0000_0000, 0, 0));
    tbl.push_back(mk(0, 0, 12'h757, 32'h0,        32'h0000_0000, 0, 1));
    tbl.push_back(mk(0, 1, 12'h3A0, 32'h0000_8F0F, 32'h0000_8F0F, 1, 1));
    tbl.push_back(mk(0, 1, 12'h3A0, 32'h0000_0000, 32'h0000_8F00, 1, 1));
    tbl.push_back(mk(0, 1, 12'h3B0, 32'h0000_1234, 32'h0000_0000, 0, 1));
    tbl.push_back(mk(0, 1, 12'h3B1, 32'h0000_FFFF, 32'h0000_0000, 0, 1));
    tbl.push_back(mk(0, 1, 12'h3B2, 32'h0000_0055, 32'h0000_0055, 1, 1));
    tbl.push_back(mk(0, 1, 12'h3B2, 32'h0000_0055, 32'h0000_0055, 0, 1));
    tbl.push_back(mk(0, 1, 12'h3C0, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0));
    tbl.push_back(mk(0, 1, 12'h3A1, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1));
    tbl.push_back(mk(0, 1, 12'h3A0, 32'h0002_0000, 32'h0000_8F00, 0, 1));
    tbl.push_back(mk(0, 1, 12'h747, 32'h0000_0001, 32'h0000_0001, 1, 1));
    tbl.push_back(mk(0, 1, 12'h3A0, 32'h0002_0000, 32'h0002_8F00, 1, 1));
    tbl.push_back(mk(0, 1, 12'h3A0, 32'h8402_8F00, 32'h0002_8F00, 0, 1));
    tbl.push_back(mk(0, 1, 12'h3A0, 32'h8702_8F00, 32'h8702_8F00, 1, 1));
    tbl.push_back(mk(0, 1, 12'h757, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1));
    tbl.push_back(mk(0, 1, 12'h747, 32'h0000_0003, 32'h0000_0003, 1, 1));
    tbl.push_back(mk(0, 1, 12'h747, 32'h0000_0000, 32'h0000_0003, 0, 1));
    tbl.push_back(mk(1, 0, 12'h747, 32'h0,        32'h0000_0000, 0, 1));
    tbl.push_back(mk(0, 0, 12'h3A0, 32'h0,        32'h0000_0000, 0, 1));

    do_reset();
    foreach (tbl[k]) begin
      if (tbl[k].rst) begin
        do_reset();
        rd(tbl[k].addr);
      end else if (tbl[k].we) begin
        wr(tbl[k].addr, tbl[k].wdata);
      end else begin
        rd(tbl[k].addr);
      end
      chk($sformatf("vec%0d_rdata", k), bus0.csr_rdata_o, tbl[k].exp_rd);
      chk($sformatf("vec%0d_changed", k), chg0, tbl[k].exp_chg);
      chk($sformatf("vec%0d_hit", k), bus0.csr_hit_o, tbl[k].exp_hit);
    end

    // Granularity 2: NAPOT sets bit 0 on read, TOR clears bits 1:0, NA4 becomes OFF.
    do_reset();
    wr(12'h3A0, 32'h0000_0018);
    wr(12'h3B0, 32'h0000_0100);
    chk("g2_napot_rd", bus1.csr_rdata_o, 32'h0000_0101);
    chk("g2_addr_o", pa1[0], 34'h400);
    chk("g0_napot_rd", bus0.csr_rdata_o, 32'h0000_0100);
    wr(12'h3A0, 32'h0000_0008);
    chk("g2_tor_cfg", bus1.csr_rdata_o, 32'h0000_0008);
    rd(12'h3B0);
    chk("g2_tor_rd", bus1.csr_rdata_o, 32'h0000_0100);
    wr(12'h3A0, 32'h0000_0010);
    chk("g2_na4_off", bus1.csr_rdata_o, 32'h0000_0000);
    chk("g0_na4_kept", bus0.csr_rdata_o, 32'h0000_0010);

    // Rule-locking bypass.
    do_reset();
    wr(12'h3A0, 32'h0000_0080);
    wr(12'h747, 32'h0000_0004);
    chk("rlb_refused_rd", bus0.csr_rdata_o, 32'h0000_0000);
    chk("rlb_refused_chg", chg0, 1'b0);
    do_reset();
`ifdef IBEX_PMP_RLB_EN
    wr(12'h747, 32'h0000_0004);
    chk("rlb_set", bus0.csr_rdata_o, 32'h0000_0004);
    wr(12'h3A0, 32'h0000_0080);
    wr(12'h3A0, 32'h0000_000F);
    chk("rlb_bypass_cfg", bus0.csr_rdata_o, 32'h0000_000F);
    wr(12'h747, 32'h0000_0000);
    chk("rlb_clear", bus0.csr_rdata_o, 32'h0000_0000);
`else
    wr(12'h747, 32'h0000_0004);
    chk("rlb_absent_rd", bus0.csr_rdata_o, 32'h0000_0000);
    chk("rlb_absent_chg", chg0, 1'b0);
`endif

    // Random writes against the model.
    do_reset();
    chk_outputs();
    for (int it = 0; it < 600; it++) begin
      if (it % 100 == 99) begin
        do_reset();
        chk_outputs();
      end
      case ($urandom_range(0, 9))
        0, 1, 2: a = 12'h3A0 + 12'($urandom_range(0, 3));
        3, 4, 5: a = 12'h3B0 + 12'($urandom_range(0, 15));
        6, 7:    a = 12'h747;
        8:       a = 12'h757;
        default: a = 12'($urandom);
      endcase
      w = $urandom;
      if (a == 12'h747) w = w & 32'h7;
      else if ($urandom_range(0, 3) != 0) w = w & 32'h7F7F_7F7F;
      wr(a, w);
      chk_outputs();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
